if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Consumer stage directly downstream of instruction fetch.
- Pairs each fetch PC with the instruction word the synchronous instruction SRAM returns one cycle later.
- Registers the pair into the IF/ID pipeline register, with stall holding and flush/bubble insertion.
- Owns a one-entry skid buffer so no SRAM read data is lost while decode is stalled, and tells fetch when to hold its PC.

Parameters:
- DATA_W, 32, width of PC and instruction.
- NOP_INST, 32'h0000_0000, instruction presented to decode when the stage holds no valid instruction.
- RESET_PC, 32'h0000_0000, value of id_pc_o and internal PC registers at reset.

Ports:
- clk  in  1  stage clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- pc_i  in  DATA_W  PC driven by fetch this cycle (address presented to SRAM).
- inst_sram_en_i  in  1  fetch SRAM enable; a read is issued in every cycle it is 1 and fetch_hold_o is 0.
- inst_sram_rdata_i  in  DATA_W  SRAM read data, valid exactly one cycle after the read is issued.
- stall_i  in  1  decode cannot accept a new instruction this cycle.
- flush_i  in  1  discard everything in this stage and in flight (branch/exception).
- fetch_hold_o  out  1  fetch must not advance PC nor issue a new read this cycle.
- id_valid_o  out  1  id_pc_o/id_inst_o hold a real instruction.
- id_pc_o  out  DATA_W  PC of the instruction in the IF/ID register.
- id_inst_o  out  DATA_W  instruction in the IF/ID register (NOP_INST when id_valid_o=0).

Behaviour:
- Reset (rst=0, async): req_valid=0, req_pc=RESET_PC, skid empty, id_valid_o=0, id_pc_o=RESET_PC, id_inst_o=NOP_INST, fetch_hold_o=0, FSM=RUN.
- Issue: a read is accepted when inst_sram_en_i=1 and fetch_hold_o=0 and flush_i=0. On accept, next cycle req_valid=1 and req_pc=pc_i; otherwise req_valid=0.
- Return: in any cycle with req_valid=1, the pair {req_pc, inst_sram_rdata_i} is the returning instruction R.
- FSM states: RUN (skid empty), SKID (skid holds one instruction).
- RUN, stall_i=0: IF/ID loads R if req_valid, else loads bubble (id_valid_o=0, id_inst_o=NOP_INST, id_pc_o unchanged). Stay in RUN.
- RUN, stall_i=1: IF/ID holds. If req_valid, R goes into the skid and the FSM goes to SKID; otherwise stay in RUN.
- SKID, stall_i=1: IF/ID and skid both hold.
- SKID, stall_i=0: IF/ID loads the skid contents and the skid empties; go to RUN.
- No read is in flight in SKID; this is guaranteed by fetch_hold_o.
- fetch_hold_o = (state==SKID) | stall_i. This is combinational, so at most one instruction is in flight plus one in the skid, and no entry is ever dropped.
- Flush: has priority over stall and all other events. Next cycle:
  - id_valid_o=0, id_inst_o=NOP_INST;
  - skid cleared, FSM=RUN;
  - req_valid=0, so any in-flight or currently returning data is discarded;
  - no new read is accepted in the flush cycle.
  - id_pc_o keeps its last value.
- Latency: pc_i accepted at cycle N appears on id_pc_o/id_inst_o at cycle N+2 when there is no stall.
- Throughput: one instruction per cycle in steady state.
- Reset mid-operation: immediately returns all state to reset values, regardless of state or in-flight read.
- Stall and flush in the same cycle: flush wins.
- inst_sram_en_i=0 (fetch held in reset) yields a continuous bubble stream.
- PC widths: no arithmetic in this block; PCs are passed through unmodified, with no wrap checks.

Decomposition:
- Shared pipeline package holds:
  - DATA_W;
  - NOP_INST;
  - RESET_PC;
  - the IF/ID payload typedef {valid, pc, inst};
  - the FSM state encoding (RUN, SKID).
- Natural sub-module: if_id_skid_buf, a one-entry holding register with load/clear/valid, reusable at the ID/EX boundary.

Test Plan:
- Reset release, inst_sram_en_i rises, then pc_i=0,4,8 with rdata=0x11,0x22,0x33 one cycle later:
  - pipeline fill: id_valid_o first 1 two cycles after the first accepted read;
  - id_pc_o/id_inst_o = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles.
- stall_i=1 for 3 cycles while PC 0x10 (rdata 0xAA) is returning:
  - fetch_hold_o=1 throughout, FSM enters SKID;
  - after the stall drops, id gets 0x10/0xAA exactly once, then 0x14 follows with no duplicate and no loss.
- flush_i=1 while 0x20 is in flight and 0x1C is in IF/ID:
  - next cycle id_valid_o=0, id_inst_o=0x0;
  - 0x20 data is never presented;
  - the first valid output afterwards is the new PC driven after the flush.
- flush_i=1 and stall_i=1 simultaneously while in SKID:
  - skid cleared, id_valid_o=0, fetch_hold_o follows stall_i only.
- rst asserted low asynchronously, mid-clock, while in SKID:
  - outputs go to reset values before the next clk edge;
  - no stale instruction appears after release.
- inst_sram_en_i held 0 for 5 cycles:
  - id_valid_o=0 and id_inst_o=NOP_INST every cycle, fetch_hold_o=0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared IF/ID pipeline definitions: widths, reset values, payload type and FSM encoding.
package if_id_stage_pkg;

    localparam int                DATA_W   = 32;
    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [DATA_W-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } if_id_payload_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        SKID = 1'b1
    } state_e;

    function automatic if_id_payload_t make_payload(input logic              valid,
                                                    input logic [DATA_W-1:0] pc,
                                                    input logic [DATA_W-1:0] inst);
        if_id_payload_t p;
        p.valid = valid;
        p.pc    = pc;
        p.inst  = inst;
        return p;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between fetch/SRAM/decode and the IF/ID stage; slave is the stage, master the environment.
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic [DATA_W-1:0] pc_i;
    logic              inst_sram_en_i;
    logic [DATA_W-1:0] inst_sram_rdata_i;
    logic              stall_i;
    logic              flush_i;
    logic              fetch_hold_o;
    logic              id_valid_o;
    logic [DATA_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;

    modport slave (
        input  pc_i, inst_sram_en_i, inst_sram_rdata_i, stall_i, flush_i,
        output fetch_hold_o, id_valid_o, id_pc_o, id_inst_o
    );

    modport master (
        output pc_i, inst_sram_en_i, inst_sram_rdata_i, stall_i, flush_i,
        input  fetch_hold_o, id_valid_o, id_pc_o, id_inst_o
    );

endinterface

// File: rtl/if_id_skid_buf.sv
// One-entry holding register for a {pc, inst} pair; clear wins over load.
module if_id_skid_buf #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: pairs fetch PC with next-cycle SRAM data, registers it for decode,
// and parks one returning instruction in a skid buffer while decode stalls.
module if_id_stage #(
    parameter int                DATA_W   = if_id_stage_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_INST = if_id_stage_pkg::NOP_INST,
    parameter logic [DATA_W-1:0] RESET_PC = if_id_stage_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    if_id_stage_if.slave bus
);
    import if_id_stage_pkg::*;

    state_e            state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [DATA_W-1:0] req_pc_q, req_pc_d;
    if_id_payload_t    id_q, id_d;

    logic              fetch_hold;
    logic              accept;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;

    // Hold fetch whenever a returning word could not be absorbed next cycle.
    always_comb begin
        fetch_hold  = (state_q == SKID) | bus.stall_i;
        accept      = bus.inst_sram_en_i & ~fetch_hold & ~bus.flush_i;
        req_valid_d = accept;
        req_pc_d    = accept ? bus.pc_i : req_pc_q;
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (bus.flush_i) begin
            state_d    = RUN;
            skid_clear = 1'b1;
            id_d       = make_payload(1'b0, id_q.pc, NOP_INST);
        end else begin
            case (state_q)
                RUN: begin
                    if (!bus.stall_i) begin
                        if (req_valid_q) begin
                            id_d = make_payload(1'b1, req_pc_q, bus.inst_sram_rdata_i);
                        end else begin
                            id_d = make_payload(1'b0, id_q.pc, NOP_INST);
                        end
                    end else if (req_valid_q) begin
                        skid_load = 1'b1;
                        state_d   = SKID;
                    end
                end
                SKID: begin
                    if (!bus.stall_i) begin
                        id_d       = make_payload(skid_valid, skid_pc, skid_inst);
                        skid_clear = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_PC;
            id_q        <= make_payload(1'b0, RESET_PC, NOP_INST);
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            id_q        <= id_d;
        end
    end

    if_id_skid_buf #(
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (req_pc_q),
        .inst_i  (bus.inst_sram_rdata_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    assign bus.fetch_hold_o = fetch_hold;
    assign bus.id_valid_o   = id_q.valid;
    assign bus.id_pc_o      = id_q.pc;
    assign bus.id_inst_o    = id_q.inst;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fill, stall/skid, flush, flush+stall, async reset, idle fetch.
module tb_if_id_stage;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, bus.id_valid_o}, {31'd0, v});
        chk({tag, "_pc"}, bus.id_pc_o, pc);
        chk({tag, "_inst"}, bus.id_inst_o, inst);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                   = 1'b0;
        bus.pc_i              = '0;
        bus.inst_sram_en_i    = 1'b0;
        bus.inst_sram_rdata_i = '0;
        bus.stall_i           = 1'b0;
        bus.flush_i           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_id("reset", 1'b0, 32'h0, 32'h0);
        chk("reset_hold", {31'd0, bus.fetch_hold_o}, 32'd0);

        // Pipeline fill: PCs 0,4,8,C
        @(negedge clk);
        rst = 1'b1;
        bus.inst_sram_en_i = 1'b1;
        bus.pc_i = 32'h0;
        tick();
        chk("fill_not_yet", {31'd0, bus.id_valid_o}, 32'd0);
        bus.pc_i = 32'h4;  bus.inst_sram_rdata_i = 32'h11;
        tick();
        chk_id("fill0", 1'b1, 32'h0, 32'h11);
        bus.pc_i = 32'h8;  bus.inst_sram_rdata_i = 32'h22;
        tick();
        chk_id("fill1", 1'b1, 32'h4, 32'h22);
        bus.pc_i = 32'hC;  bus.inst_sram_rdata_i = 32'h33;
        tick();
        chk_id("fill2", 1'b1, 32'h8, 32'h33);
        bus.pc_i = 32'h10; bus.inst_sram_rdata_i = 32'h44;
        tick();
        chk_id("fill3", 1'b1, 32'hC, 32'h44);

        // Stall for 3 cycles while 0x10/0xAA returns
        bus.pc_i = 32'h14; bus.inst_sram_rdata_i = 32'hAA; bus.stall_i = 1'b1;
        #1;
        chk("stall_hold0", {31'd0, bus.fetch_hold_o}, 32'd1);
        tick();
        bus.inst_sram_rdata_i = 32'hDEAD;
        chk("stall_hold1", {31'd0, bus.fetch_hold_o}, 32'd1);
        chk_id("stall_idhold", 1'b1, 32'hC, 32'h44);
        tick();
        chk("stall_hold2", {31'd0, bus.fetch_hold_o}, 32'd1);
        tick();
        bus.stall_i = 1'b0;
        #1;
        chk("skid_hold", {31'd0, bus.fetch_hold_o}, 32'd1);
        chk_id("skid_idhold", 1'b1, 32'hC, 32'h44);
        tick();
        chk_id("skid_out", 1'b1, 32'h10, 32'hAA);
        chk("run_nohold", {31'd0, bus.fetch_hold_o}, 32'd0);
        tick();
        chk_id("after_skid_bubble", 1'b0, 32'h10, 32'h0);
        bus.inst_sram_rdata_i = 32'h55; bus.pc_i = 32'h18;
        tick();
        chk_id("after_skid_next", 1'b1, 32'h14, 32'h55);

        // Flush with 0x1C in IF/ID and 0x20 in flight
        bus.inst_sram_rdata_i = 32'h66; bus.pc_i = 32'h1C;
        tick();
        chk_id("pre_flush0", 1'b1, 32'h18, 32'h66);
        bus.inst_sram_rdata_i = 32'h77; bus.pc_i = 32'h20;
        tick();
        chk_id("pre_flush1", 1'b1, 32'h1C, 32'h77);
        bus.inst_sram_rdata_i = 32'h88; bus.pc_i = 32'h24; bus.flush_i = 1'b1;
        tick();
        chk_id("flush", 1'b0, 32'h1C, 32'h0);
        bus.flush_i = 1'b0; bus.pc_i = 32'h100;
        tick();
        chk_id("post_flush_bubble", 1'b0, 32'h1C, 32'h0);
        bus.inst_sram_rdata_i = 32'h99; bus.pc_i = 32'h104;
        tick();
        chk_id("post_flush_new", 1'b1, 32'h100, 32'h99);

        // Flush and stall together while in SKID
        bus.inst_sram_rdata_i = 32'hBB; bus.stall_i = 1'b1;
        tick();
        chk_id("skid2_idhold", 1'b1, 32'h100, 32'h99);
        bus.flush_i = 1'b1;
        #1;
        chk("fs_hold", {31'd0, bus.fetch_hold_o}, 32'd1);
        tick();
        chk_id("fs_flush", 1'b0, 32'h100, 32'h0);
        bus.flush_i = 1'b0;
        #1;
        chk("fs_hold_stall", {31'd0, bus.fetch_hold_o}, 32'd1);
        bus.stall_i = 1'b0; bus.pc_i = 32'h200;
        #1;
        chk("fs_hold_free", {31'd0, bus.fetch_hold_o}, 32'd0);
        tick();
        chk_id("fs_no_skid_out", 1'b0, 32'h100, 32'h0);
        bus.inst_sram_rdata_i = 32'h2A; bus.pc_i = 32'h204;
        tick();
        chk_id("fs_new", 1'b1, 32'h200, 32'h2A);

        // Asynchronous reset mid-cycle while in SKID
        bus.inst_sram_rdata_i = 32'hCC; bus.stall_i = 1'b1;
        tick();
        chk_id("rst_pre", 1'b1, 32'h200, 32'h2A);
        #1;
        rst = 1'b0;
        #1;
        chk_id("rst_async", 1'b0, 32'h0, 32'h0);
        bus.stall_i = 1'b0;
        bus.inst_sram_en_i = 1'b0;
        #1;
        chk("rst_hold", {31'd0, bus.fetch_hold_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fetch idle: bubble stream, no stale instruction
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", {31'd0, bus.id_valid_o}, 32'd0);
            chk("idle_inst", bus.id_inst_o, 32'h0);
            chk("idle_hold", {31'd0, bus.fetch_hold_o}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
